// File: rtl/frame_mem_if.sv
// Split write/read request bus between the frame-buffer master and the
// memory responder. The master holds write/read high until the matching
// waitrequest drops for one cycle.
interface frame_mem_if;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        write;
    logic        write_waitrequest;
    logic [31:0] read_addr;
    logic        read;
    logic [31:0] read_data;
    logic        read_waitrequest;

    modport master (
        output write_addr, write_data, write, read_addr, read,
        input  write_waitrequest, read_data, read_waitrequest
    );

    modport slave (
        input  write_addr, write_data, write, read_addr, read,
        output write_waitrequest, read_data, read_waitrequest
    );
endinterface

// File: rtl/frame_mem_responder.sv
// On-chip stand-in for the frame-buffer DRAM: one single-port word array
// shared by the write and read ports, round-robin arbitration between the
// two, WAIT_CYCLES wait states per access and a sticky out-of-range flag.
module frame_mem_responder #(
    parameter int DEPTH       = 640,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              ctrl_clk,
    input  logic              reset_n,
    frame_mem_if.slave        bus,
    output logic              addr_err,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;
    // Transfer kind; the round-robin pointer reuses it to name the port
    // that wins the next simultaneous request.
    typedef enum logic {KIND_W = 1'b0, KIND_R = 1'b1} kind_e;

    logic [31:0] mem [DEPTH];

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    kind_e       prio_q, prio_d;
    logic [29:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_wait_q, wr_wait_d;
    logic        rd_wait_q, rd_wait_d;
    logic [31:0] read_data_q, read_data_d;
    logic        addr_err_q, addr_err_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic        grant;
    logic        in_range_q, in_range_d;

    // Byte-lane bits of the addresses are not used: access is word-only.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.write_addr[1:0], bus.read_addr[1:0]};

    assign in_range_q = (idx_q < DEPTH_W);
    assign in_range_d = (idx_d < DEPTH_W);

    // Next-state: arbitration, wait-state countdown, ack and read-data setup.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        kind_d      = kind_q;
        prio_d      = prio_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        wr_wait_d   = 1'b1;
        rd_wait_d   = 1'b1;
        read_data_d = read_data_q;
        addr_err_d  = addr_err_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        grant       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.write && (!bus.read || prio_q == KIND_W)) begin
                    grant  = 1'b1;
                    kind_d = KIND_W;
                    idx_d  = bus.write_addr[31:2];
                    prio_d = KIND_R;
                end else if (bus.read) begin
                    grant  = 1'b1;
                    kind_d = KIND_R;
                    idx_d  = bus.read_addr[31:2];
                    prio_d = KIND_W;
                end
                if (grant) begin
                    wdata_d = bus.write_data;
                    cnt_d   = WAIT_W;
                    state_d = (WAIT_CYCLES == 0) ? ACK : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
                if (kind_q == KIND_W) wr_count_d = wr_count_q + 16'd1;
                else                  rd_count_d = rd_count_q + 16'd1;
                if (!in_range_q) addr_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // ACK always returns to IDLE, so state_d == ACK means "entering ACK".
        if (state_d == ACK) begin
            if (kind_d == KIND_W) begin
                wr_wait_d = 1'b0;
            end else begin
                rd_wait_d   = 1'b0;
                read_data_d = in_range_d ? mem[idx_d[AW-1:0]] : 32'h0;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ctrl_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!reset_n) begin
            state_q     <= IDLE;
            kind_q      <= KIND_W;
            prio_q      <= KIND_W;
            idx_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            wr_wait_q   <= 1'b1;
            rd_wait_q   <= 1'b1;
            read_data_q <= '0;
            addr_err_q  <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            prio_q      <= prio_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            wr_wait_q   <= wr_wait_d;
            rd_wait_q   <= rd_wait_d;
            read_data_q <= read_data_d;
            addr_err_q  <= addr_err_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
        end
    end

    // Write commit at the end of ACK; gated by reset so an interrupted
    // transfer never lands in memory.
    always_ff @(posedge ctrl_clk) begin
        // NOTE: the array has no reset branch; clearing it would defeat
        // block-RAM mapping, and its contents are defined by prior writes.
        if (reset_n && state_q == ACK && kind_q == KIND_W && in_range_q)
            mem[idx_q[AW-1:0]] <= wdata_q;
    end

    assign bus.write_waitrequest = wr_wait_q;
    assign bus.read_waitrequest  = rd_wait_q;
    assign bus.read_data         = read_data_q;
    assign addr_err              = addr_err_q;
    assign wr_count              = wr_count_q;
    assign rd_count              = rd_count_q;

endmodule

// File: tb/tb_frame_mem_responder.sv
// Bench for frame_mem_responder: instance A with WAIT_CYCLES=2 and instance
// B with WAIT_CYCLES=0. Stimulus pushes expected acks (kind, cycle, read
// data) into per-instance queues; monitors pop them on every ack.
module tb_frame_mem_responder;

    localparam int DEPTH = 640;

    typedef struct {
        bit          is_write;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic ctrl_clk = 1'b0;
    logic reset_n  = 1'b0;
    int   cyc      = 0;
    int   tests    = 0;
    int   fails    = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    frame_mem_if bus_a ();
    frame_mem_if bus_b ();

    logic        addr_err_a, addr_err_b;
    logic [15:0] wr_count_a, wr_count_b, rd_count_a, rd_count_b;

    frame_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_a (
        .ctrl_clk (ctrl_clk),
        .reset_n  (reset_n),
        .bus      (bus_a.slave),
        .addr_err (addr_err_a),
        .wr_count (wr_count_a),
        .rd_count (rd_count_a)
    );

    frame_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
        .ctrl_clk (ctrl_clk),
        .reset_n  (reset_n),
        .bus      (bus_b.slave),
        .addr_err (addr_err_b),
        .wr_count (wr_count_b),
        .rd_count (rd_count_b)
    );

    always #5 ctrl_clk = ~ctrl_clk;
    always @(posedge ctrl_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Pops one expected ack for instance sel and compares it with what the DUT shows.
    task automatic score(input bit sel, input logic wlow, input logic [31:0] rdata);
        exp_t  e;
        string p;
        int    depth;
        p     = sel ? "B" : "A";
        depth = sel ? q_b.size() : q_a.size();
        if (depth == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_unexpected_ack: got ack at cycle %0d, required none", p, cyc);
        end else begin
            if (sel) e = q_b.pop_front();
            else     e = q_a.pop_front();
            check({p, "_ack_kind"}, {31'b0, wlow}, {31'b0, e.is_write});
            check({p, "_ack_cycle"}, cyc, e.cyc);
            if (!e.is_write) check({p, "_read_data"}, rdata, e.data);
        end
    endtask

    always @(negedge ctrl_clk) begin
        if (reset_n === 1'b1) begin
            if (bus_a.write_waitrequest === 1'b0 || bus_a.read_waitrequest === 1'b0)
                score(1'b0, ~bus_a.write_waitrequest, bus_a.read_data);
            if (bus_b.write_waitrequest === 1'b0 || bus_b.read_waitrequest === 1'b0)
                score(1'b1, ~bus_b.write_waitrequest, bus_b.read_data);
        end
    end

    function automatic logic get_wait(input bit sel, input bit w);
        if (sel) return w ? bus_b.write_waitrequest : bus_b.read_waitrequest;
        else     return w ? bus_a.write_waitrequest : bus_a.read_waitrequest;
    endfunction

    // One master transfer. Entered and left #1 after a rising edge with the
    // DUT idle; the expected ack lands WAIT_CYCLES+1 cycles after the request.
    task automatic do_xfer(input bit sel, input bit w, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] expd);
        exp_t e;
        int   n;
        e.is_write = w;
        e.data     = expd;
        e.cyc      = cyc + (sel ? 0 : 2) + 1;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        if (sel) begin
            if (w) begin bus_b.write_addr = addr; bus_b.write_data = wdata; bus_b.write = 1'b1; end
            else   begin bus_b.read_addr = addr; bus_b.read = 1'b1; end
        end else begin
            if (w) begin bus_a.write_addr = addr; bus_a.write_data = wdata; bus_a.write = 1'b1; end
            else   begin bus_a.read_addr = addr; bus_a.read = 1'b1; end
        end
        n = 0;
        do begin
            @(negedge ctrl_clk);
            n++;
        end while (get_wait(sel, w) !== 1'b0 && n < 100);
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL %s_ack_timeout: got no ack in %0d cycles, required ack", sel ? "B" : "A", n);
        end
        @(posedge ctrl_clk);
        #1;
        if (sel) begin bus_b.write = 1'b0; bus_b.read = 1'b0; end
        else     begin bus_a.write = 1'b0; bus_a.read = 1'b0; end
    endtask

    initial begin
        int   k;
        exp_t e;
        bus_a.write = 1'b0; bus_a.read = 1'b0;
        bus_a.write_addr = '0; bus_a.write_data = '0; bus_a.read_addr = '0;
        bus_b.write = 1'b0; bus_b.read = 1'b0;
        bus_b.write_addr = '0; bus_b.write_data = '0; bus_b.read_addr = '0;

        // Reset and idle.
        repeat (3) @(posedge ctrl_clk);
        #1;
        check("rst_wr_wait", {31'b0, bus_a.write_waitrequest}, 32'd1);
        check("rst_rd_wait", {31'b0, bus_a.read_waitrequest}, 32'd1);
        check("rst_read_data", bus_a.read_data, 32'h0);
        check("rst_addr_err", {31'b0, addr_err_a}, 32'd0);
        check("rst_wr_count", {16'b0, wr_count_a}, 32'd0);
        check("rst_rd_count", {16'b0, rd_count_a}, 32'd0);
        reset_n = 1'b1;

        // Single write then read with two wait states.
        do_xfer(0, 1, 32'h10, 32'hCAFE0001, 32'h0);
        do_xfer(0, 0, 32'h10, 32'h0, 32'hCAFE0001);
        check("rd_data_hold", bus_a.read_data, 32'hCAFE0001);
        check("a_wr_count_1", {16'b0, wr_count_a}, 32'd1);
        check("a_rd_count_1", {16'b0, rd_count_a}, 32'd1);

        // Preload for later tests.
        do_xfer(0, 1, 32'h4, 32'h44440004, 32'h0);
        do_xfer(0, 1, 32'h8, 32'h11111111, 32'h0);
        check("addr_err_clear", {31'b0, addr_err_a}, 32'd0);

        // Out-of-range accesses.
        do_xfer(0, 1, DEPTH * 4, 32'h12345678, 32'h0);
        check("addr_err_set", {31'b0, addr_err_a}, 32'd1);
        do_xfer(0, 0, DEPTH * 4, 32'h0, 32'h0);
        do_xfer(0, 0, 32'h10, 32'h0, 32'hCAFE0001);
        do_xfer(0, 0, 32'h4, 32'h0, 32'h44440004);
        check("addr_err_sticky", {31'b0, addr_err_a}, 32'd1);
        check("a_wr_count_oor", {16'b0, wr_count_a}, 32'd4);
        check("a_rd_count_oor", {16'b0, rd_count_a}, 32'd4);

        // Full-frame sweep with zero wait states, wrapping back to index 0.
        for (int i = 0; i <= DEPTH; i++)
            do_xfer(1, 1, (i % DEPTH) * 4, i % DEPTH, 32'h0);
        for (int i = 0; i < DEPTH; i++)
            do_xfer(1, 0, i * 4, 32'h0, i);
        check("b_wr_count", {16'b0, wr_count_b}, DEPTH + 1);
        check("b_rd_count", {16'b0, rd_count_b}, DEPTH);
        check("b_addr_err", {31'b0, addr_err_b}, 32'd0);

        // Reset while a write is in BUSY: no ack, no commit, counters cleared.
        bus_a.write_addr = 32'h8;
        bus_a.write_data = 32'hFFFFFFFF;
        bus_a.write      = 1'b1;
        @(posedge ctrl_clk);
        #1;
        reset_n     = 1'b0;
        bus_a.write = 1'b0;
        @(posedge ctrl_clk);
        #1;
        reset_n = 1'b1;
        check("mid_rst_wr_count", {16'b0, wr_count_a}, 32'd0);
        check("mid_rst_addr_err", {31'b0, addr_err_a}, 32'd0);
        check("mid_rst_wr_wait", {31'b0, bus_a.write_waitrequest}, 32'd1);
        do_xfer(0, 0, 32'h8, 32'h0, 32'h11111111);
        check("mid_rst_wr_count_after", {16'b0, wr_count_a}, 32'd0);
        check("mid_rst_rd_count_after", {16'b0, rd_count_a}, 32'd1);

        // Both ports requesting continuously from reset: W first, then W/R
        // alternate with one ack every 4 cycles.
        reset_n          = 1'b0;
        bus_a.write_addr = 32'h0;
        bus_a.write_data = 32'hA5A50000;
        bus_a.write      = 1'b1;
        bus_a.read_addr  = 32'h4;
        bus_a.read       = 1'b1;
        @(posedge ctrl_clk);
        #1;
        reset_n = 1'b1;
        k = cyc;
        for (int i = 0; i < 8; i++) begin
            e.is_write = (i % 2 == 0);
            e.data     = 32'h44440004;
            e.cyc      = k + 3 + 4 * i;
            q_a.push_back(e);
        end
        repeat (32) @(posedge ctrl_clk);
        #1;
        bus_a.write = 1'b0;
        bus_a.read  = 1'b0;
        check("rr_wr_count", {16'b0, wr_count_a}, 32'd4);
        check("rr_rd_count", {16'b0, rd_count_a}, 32'd4);
        do_xfer(0, 0, 32'h0, 32'h0, 32'hA5A50000);

        repeat (4) @(posedge ctrl_clk);
        #1;
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
